// File: rtl/call_request_latch_if.sv
// rtl/call_request_latch_if.sv - cab-call request bus between FSM side and request latch
//
// Signals:
//   btn[3:0]           raw asynchronous cab buttons, bit i = floor i (driven by master)
//   current_floor[1:0] floor the cab is at or passing (driven by master)
//   arrived            one-cycle pulse, cab stopped at current_floor (driven by master)
//   pending[3:0]       latched outstanding calls (driven by slave)
//   req_valid          a target exists on req_floor (driven by slave)
//   req_floor[1:0]     arbitrated target floor (driven by slave)
//   req_up             SCAN direction, 1 = up (driven by slave)

interface call_request_latch_if;
    logic [3:0] btn;
    logic [1:0] current_floor;
    logic       arrived;
    logic [3:0] pending;
    logic       req_valid;
    logic [1:0] req_floor;
    logic       req_up;

    modport master (
        output btn,
        output current_floor,
        output arrived,
        input  pending,
        input  req_valid,
        input  req_floor,
        input  req_up
    );

    modport slave (
        input  btn,
        input  current_floor,
        input  arrived,
        output pending,
        output req_valid,
        output req_floor,
        output req_up
    );
endinterface

// File: rtl/call_request_latch.sv
// rtl/call_request_latch.sv - cab-call conditioning, pending latch and SCAN target arbiter
//
// Ports:
//   clk    system clock, all state on rising edge
//   reset  synchronous active-high reset, dominates every other input that cycle
//   bus    call_request_latch_if.slave (btn/current_floor/arrived in,
//          pending/req_valid/req_floor/req_up out)
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing synchronised samples needed to move a
//                    debounced level (>= 1)
//   DB_W             debounce counter width, 2**DB_W must exceed DEBOUNCE_CYCLES

module call_request_latch #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DB_W            = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    call_request_latch_if.slave  bus
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Two-flop synchroniser; only the second stage is used downstream.
    logic [3:0]      sync1_q;
    logic [3:0]      sync2_q;

    // Debouncer state.
    logic [3:0]      db_q;
    logic [3:0]      db_d;
    logic [3:0]      db_prev_q;
    logic [DB_W-1:0] cnt_q [4];
    logic [DB_W-1:0] cnt_d [4];

    // Call latch.
    logic [3:0]      press;
    logic [3:0]      clear;
    logic [3:0]      pending_q;
    logic [3:0]      pending_d;

    // Arbiter.
    logic [3:0]      above;
    logic [3:0]      below;
    logic            here;
    logic [1:0]      lo_above;
    logic [1:0]      hi_below;
    logic            req_valid_q;
    logic            req_valid_d;
    logic [1:0]      req_floor_q;
    logic [1:0]      req_floor_d;
    logic            req_up_q;
    logic            req_up_d;

    // ------------------------------------------------------------------
    // Debounce: the counter tracks how many consecutive samples have
    // disagreed with the debounced level. Any agreeing sample restarts it,
    // so only an uninterrupted run of DEBOUNCE_CYCLES disagreements moves
    // the level.
    // ------------------------------------------------------------------
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]  = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Press = registered debounced level rising. Holding a button keeps
    // db high, so it yields a single press until it is released and
    // debounced low again.
    // ------------------------------------------------------------------
    assign press = db_q & ~db_prev_q;

    always_comb begin
        clear = '0;
        for (int i = 0; i < 4; i++) begin
            clear[i] = bus.arrived && (bus.current_floor == 2'(i));
        end
    end

    // Clear is applied after the OR so an arrival beats a same-cycle press.
    assign pending_d = (pending_q | press) & ~clear;

    // ------------------------------------------------------------------
    // SCAN arbiter, evaluated from registered pending every cycle.
    // ------------------------------------------------------------------
    always_comb begin
        above = '0;
        below = '0;
        for (int i = 0; i < 4; i++) begin
            if (2'(i) > bus.current_floor) above[i] = pending_q[i];
            if (2'(i) < bus.current_floor) below[i] = pending_q[i];
        end
    end

    assign here = pending_q[bus.current_floor];

    // Nearest call above = lowest set index; descending scan so the last hit wins.
    always_comb begin
        lo_above = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (above[i]) lo_above = 2'(i);
        end
    end

    // Nearest call below = highest set index; ascending scan so the last hit wins.
    always_comb begin
        hi_below = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (below[i]) hi_below = 2'(i);
        end
    end

    always_comb begin
        req_valid_d = |pending_q;
        req_floor_d = req_floor_q;
        req_up_d    = req_up_q;
        if (here) begin
            req_floor_d = bus.current_floor;
        end else if (req_up_q) begin
            if (|above) begin
                req_floor_d = lo_above;
            end else if (|below) begin
                req_floor_d = hi_below;
                req_up_d    = 1'b0;
            end
        end else begin
            if (|below) begin
                req_floor_d = hi_below;
            end else if (|above) begin
                req_floor_d = lo_above;
                req_up_d    = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            db_prev_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            pending_q   <= '0;
            req_valid_q <= 1'b0;
            req_floor_q <= 2'd0;
            req_up_q    <= 1'b1;
        end else begin
            sync1_q     <= bus.btn;
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            db_prev_q   <= db_q;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pending_q   <= pending_d;
            req_valid_q <= req_valid_d;
            req_floor_q <= req_floor_d;
            req_up_q    <= req_up_d;
        end
    end

    assign bus.pending   = pending_q;
    assign bus.req_valid = req_valid_q;
    assign bus.req_floor = req_floor_q;
    assign bus.req_up    = req_up_q;

endmodule

// File: tb/tb_call_request_latch.sv
// tb/tb_call_request_latch.sv - directed and randomized checks of call_request_latch

module tb_call_request_latch;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    call_request_latch_if bus ();

    call_request_latch #(
        .DEBOUNCE_CYCLES (DC),
        .DB_W            (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass   = 0;
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: btn delay line, window of the last DC synchronised
    // samples, set-based pending, distance-search SCAN.
    logic [3:0] m_s1, m_s2, m_db, m_db_prev, m_pend;
    logic [3:0] m_hist [$];
    logic       m_rv, m_up;
    logic [1:0] m_rf;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [3:0] b, input logic [1:0] cf,
                              input logic arr, input logic rst);
        logic [3:0] nxt_pend;
        logic [3:0] nxt_db;
        logic       nxt_up;
        logic [1:0] nxt_rf;
        logic       found;
        logic       all_diff;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_db_prev = '0; m_pend = '0;
            m_rv = 1'b0; m_rf = 2'd0; m_up = 1'b1;
            m_hist.delete();
            for (int k = 0; k < DC; k++) m_hist.push_back(4'b0000);
        end else begin
            nxt_pend = m_pend | (m_db & ~m_db_prev);
            if (arr) nxt_pend[cf] = 1'b0;

            nxt_rf = m_rf;
            nxt_up = m_up;
            if (m_pend != 4'b0000) begin
                if (m_pend[cf]) begin
                    nxt_rf = cf;
                end else begin
                    found = 1'b0;
                    if (m_up) begin
                        for (int f = int'(cf) + 1; f <= 3; f++)
                            if (!found && m_pend[f]) begin nxt_rf = 2'(f); found = 1'b1; end
                        for (int f = int'(cf) - 1; f >= 0; f--)
                            if (!found && m_pend[f]) begin nxt_rf = 2'(f); nxt_up = 1'b0; found = 1'b1; end
                    end else begin
                        for (int f = int'(cf) - 1; f >= 0; f--)
                            if (!found && m_pend[f]) begin nxt_rf = 2'(f); found = 1'b1; end
                        for (int f = int'(cf) + 1; f <= 3; f++)
                            if (!found && m_pend[f]) begin nxt_rf = 2'(f); nxt_up = 1'b1; found = 1'b1; end
                    end
                end
            end

            m_hist.push_back(m_s2);
            if (m_hist.size() > DC) void'(m_hist.pop_front());
            nxt_db = m_db;
            for (int i = 0; i < 4; i++) begin
                all_diff = 1'b1;
                foreach (m_hist[k]) if (m_hist[k][i] == m_db[i]) all_diff = 1'b0;
                if (all_diff) nxt_db[i] = ~m_db[i];
            end

            m_rv      = |m_pend;
            m_rf      = nxt_rf;
            m_up      = nxt_up;
            m_pend    = nxt_pend;
            m_db_prev = m_db;
            m_db      = nxt_db;
            m_s2      = m_s1;
            m_s1      = b;
        end
    endtask

    task automatic tick(input logic [3:0] b, input logic [1:0] cf,
                        input logic arr, input logic rst);
        bus.btn           = b;
        bus.current_floor = cf;
        bus.arrived       = arr;
        reset             = rst;
        model_step(b, cf, arr, rst);
        @(posedge clk);
        #1;
        check("model_pending",   bus.pending,          m_pend);
        check("model_req_valid", {3'b0, bus.req_valid}, {3'b0, m_rv});
        check("model_req_floor", {2'b0, bus.req_floor}, {2'b0, m_rf});
        check("model_req_up",    {3'b0, bus.req_up},    {3'b0, m_up});
    endtask

    logic [3:0] rbtn;
    logic [1:0] rcf;

    initial begin
        bus.btn = '0; bus.current_floor = '0; bus.arrived = 1'b0; reset = 1'b1;
        @(posedge clk); #1;

        // Reset state
        tick(4'b0000, 2'd0, 1'b0, 1'b1);
        check("rst_pending", bus.pending, 4'b0000);
        check("rst_valid",   {3'b0, bus.req_valid}, 4'd0);
        check("rst_floor",   {2'b0, bus.req_floor}, 4'd0);
        check("rst_up",      {3'b0, bus.req_up},    4'd1);

        // Floor 2 held 10 cycles from floor 0: pending on tick 7, request on tick 8
        repeat (6) tick(4'b0100, 2'd0, 1'b0, 1'b0);
        check("p1_not_yet", bus.pending, 4'b0000);
        tick(4'b0100, 2'd0, 1'b0, 1'b0);
        check("p1_pending", bus.pending, 4'b0100);
        check("p1_valid_lag", {3'b0, bus.req_valid}, 4'd0);
        tick(4'b0100, 2'd0, 1'b0, 1'b0);
        check("p1_valid", {3'b0, bus.req_valid}, 4'd1);
        check("p1_floor", {2'b0, bus.req_floor}, 4'd2);
        check("p1_up",    {3'b0, bus.req_up},    4'd1);
        repeat (2)  tick(4'b0100, 2'd0, 1'b0, 1'b0);
        repeat (10) tick(4'b0000, 2'd0, 1'b0, 1'b0);
        tick(4'b0000, 2'd2, 1'b1, 1'b0);
        check("p1_cleared", bus.pending, 4'b0000);
        tick(4'b0000, 2'd2, 1'b0, 1'b0);
        check("p1_idle", {3'b0, bus.req_valid}, 4'd0);

        // 2-cycle glitch on floor 1 is rejected
        repeat (2)  tick(4'b0010, 2'd2, 1'b0, 1'b0);
        repeat (10) tick(4'b0000, 2'd2, 1'b0, 1'b0);
        check("p2_pending", bus.pending, 4'b0000);
        check("p2_valid",   {3'b0, bus.req_valid}, 4'd0);

        // Floors 1 and 3 together, cab at 2 going up -> 3, then reverse to 1
        repeat (8) tick(4'b1010, 2'd2, 1'b0, 1'b0);
        repeat (8) tick(4'b0000, 2'd2, 1'b0, 1'b0);
        check("p3_pending", bus.pending, 4'b1010);
        check("p3_floor",   {2'b0, bus.req_floor}, 4'd3);
        check("p3_up",      {3'b0, bus.req_up},    4'd1);
        tick(4'b0000, 2'd3, 1'b1, 1'b0);
        check("p3_clear3", bus.pending, 4'b0010);
        tick(4'b0000, 2'd2, 1'b0, 1'b0);
        check("p3_floor_rev", {2'b0, bus.req_floor}, 4'd1);
        check("p3_up_rev",    {3'b0, bus.req_up},    4'd0);
        tick(4'b0000, 2'd1, 1'b1, 1'b0);
        tick(4'b0000, 2'd1, 1'b0, 1'b0);
        check("p3_idle", {3'b0, bus.req_valid}, 4'd0);

        // Arrival coincides with a fresh press of the same floor: clear wins
        repeat (8)  tick(4'b0100, 2'd2, 1'b0, 1'b0);
        repeat (10) tick(4'b0000, 2'd2, 1'b0, 1'b0);
        check("p4_pending", bus.pending, 4'b0100);
        check("p4_valid",   {3'b0, bus.req_valid}, 4'd1);
        repeat (6) tick(4'b0100, 2'd2, 1'b0, 1'b0);
        tick(4'b0100, 2'd2, 1'b1, 1'b0);
        check("p4_clear_wins", bus.pending, 4'b0000);
        tick(4'b0100, 2'd2, 1'b0, 1'b0);
        check("p4_valid_drop", {3'b0, bus.req_valid}, 4'd0);

        // Keep holding: no re-latch until released and pressed again
        repeat (42) tick(4'b0100, 2'd2, 1'b0, 1'b0);
        check("p5_no_relatch", bus.pending, 4'b0000);
        repeat (10) tick(4'b0000, 2'd2, 1'b0, 1'b0);
        repeat (8)  tick(4'b0100, 2'd2, 1'b0, 1'b0);
        check("p5_repress", bus.pending, 4'b0100);
        tick(4'b0000, 2'd2, 1'b1, 1'b0);
        repeat (10) tick(4'b0000, 2'd2, 1'b0, 1'b0);

        // Reset with floors 0 and 3 pending, buttons still held
        repeat (8) tick(4'b1001, 2'd1, 1'b0, 1'b0);
        check("p6_pending", bus.pending, 4'b1001);
        tick(4'b1001, 2'd1, 1'b0, 1'b1);
        check("p6_rst_pending", bus.pending, 4'b0000);
        check("p6_rst_valid",   {3'b0, bus.req_valid}, 4'd0);
        check("p6_rst_up",      {3'b0, bus.req_up},    4'd1);
        repeat (6) tick(4'b1001, 2'd1, 1'b0, 1'b0);
        check("p6_wait", bus.pending, 4'b0000);
        tick(4'b1001, 2'd1, 1'b0, 1'b0);
        check("p6_relatch", bus.pending, 4'b1001);
        repeat (10) tick(4'b0000, 2'd1, 1'b0, 1'b0);

        // Randomized traffic against the model
        rbtn = '0;
        rcf  = 2'd0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) rbtn[i] = ~rbtn[i];
            if ($urandom_range(0, 2) == 0) rcf = 2'($urandom_range(0, 3));
            tick(rbtn, rcf, ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/call_request_latch.md
Name: call_request_latch

Overview:
- Sits directly upstream of the floor-request decoder and the elevator FSM.
- Conditions the four raw cab-call buttons (floors 0-3): synchronise, debounce, edge-detect.
- Latches each call as pending until the cab arrives at that floor.
- Presents one arbitrated target floor per cycle, chosen with SCAN (continue current direction, nearest first). The FSM consumes it as its next-stage request.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required before a debounced level changes. Minimum 1.
- DB_W, 3: width of each debounce counter. Must satisfy 2^DB_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn  input  4  raw asynchronous cab buttons; bit i = floor i, active high.
- current_floor  input  2  floor the cab is at or passing, from FSM.
- arrived  input  1  one-cycle pulse: cab stopped at current_floor, doors opening.
- pending  output  4  latched outstanding calls; bit i = floor i.
- req_valid  output  1  a target exists on req_floor.
- req_floor  output  2  arbitrated target floor.
- req_up  output  1  SCAN direction register; 1 = up.

Behaviour:
- Reset (synchronous, dominates all other inputs that cycle):
  - sync flops, debounced levels, counters, pending, req_valid and req_floor all go to 0.
  - req_up goes to 1.
- Synchroniser: two flops per button. Only the second-stage output (s_i) feeds the debouncer.
- Debouncer, per button:
  - If s_i equals the debounced level db_i, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while s_i still differs, db_i <= s_i and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles leaves db_i unchanged.
- Edge detect: press_i = db_i rising, a one-cycle internal pulse. Falling edges are ignored. Holding a button generates exactly one press.
- Pending update, per bit i, each cycle:
  - clear_i = arrived & (current_floor == i).
  - pending_i <= clear_i ? 0 : (pending_i | press_i). Clear wins over a simultaneous press of the same floor.
  - A re-press of an already-pending floor has no effect.
- Arbiter: combinational from registered pending, current_floor and req_up; result registered into req_valid/req_floor/req_up.
  - above = pending bits with index > current_floor; below = index < current_floor; here = pending[current_floor].
  - If here: req_floor = current_floor, direction unchanged.
  - Else if req_up: if above is nonzero, choose the lowest set index in above; else if below is nonzero, choose the highest set index in below and set req_up <= 0.
  - Else (req_up = 0): if below is nonzero, choose the highest below; else if above is nonzero, choose the lowest above and set req_up <= 1.
  - req_valid <= |pending. If pending == 0: req_valid = 0, req_floor holds its last value, req_up holds.
- Latency:
  - Debounced press at cycle N sets pending at N+1.
  - req_valid/req_floor reflect it at N+2.
  - arrived at cycle M clears the bit at M+1; the arbiter output updates at M+2.
- Boundaries:
  - current_floor = 3 gives above = 0; current_floor = 0 gives below = 0. No wrap-around.
  - Simultaneous presses of several floors all latch in the same cycle.
  - arrived with no matching pending bit is harmless.
  - Reset mid-debounce or with calls pending discards everything; calls must be re-pressed.
  - current_floor changing every cycle is permitted; the arbiter re-evaluates each cycle with no hysteresis beyond req_up.

Test Plan:
1. Reset, then btn[2] held 10 cycles with DEBOUNCE_CYCLES = 4, current_floor = 0 -> pending = 4'b0100; req_valid = 1, req_floor = 2, req_up = 1, at the latency above relative to the debounced edge.
2. btn[1] pulsed for 2 cycles only (glitch) -> pending stays 0, req_valid stays 0.
3. pending = 4'b1010, current_floor = 2, req_up = 1 -> req_floor = 3. Then pending = 4'b0010 (floor 3 cleared) -> req_floor = 1, req_up = 0 one cycle later.
4. pending[2] = 1, current_floor = 2, arrived pulse in the same cycle as a fresh debounced press of btn[2] -> pending[2] = 0 next cycle; req_valid = 0 two cycles later.
5. btn held continuously 50 cycles, arrived clears its floor mid-hold -> no re-latch until the button is released and pressed again.
6. Calls pending on floors 0 and 3, reset asserted for 1 cycle -> next cycle pending = 0, req_valid = 0, req_up = 1; btn still held after reset re-latches only after full sync + debounce delay.
